// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: address width, memory size, program origin and the
// fetch-stage state encoding.
package chip8_pkg;

  localparam int                CHIP8_ADDR_W    = 12;
  localparam int                CHIP8_MEM_DEPTH = 4096;
  localparam logic [11:0]       CHIP8_PROG_BASE = 12'h200;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_HI  = 3'd1,
    S_RD_LO  = 3'd2,
    S_CAP_LO = 3'd3,
    S_VALID  = 3'd4,
    S_HALT   = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: owns the PC, reads two big-endian opcode bytes from
// synchronous-read program memory. Optional bounds fault: CHIP8_FETCH_BOUNDS_EN.
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter logic [CHIP8_ADDR_W-1:0] RESET_PC = CHIP8_PROG_BASE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    pc_load,
  input  logic [CHIP8_ADDR_W-1:0] pc_load_value,
  output logic [CHIP8_ADDR_W-1:0] mem_address,
  input  logic [7:0]              mem_data_out,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [15:0]             opcode,
  output logic [CHIP8_ADDR_W-1:0] op_pc,
  output logic [CHIP8_ADDR_W-1:0] pc,
  output logic                    fault,
  output fetch_state_t            dbg_state
);

  // Handshake: an opcode transfers on any rising edge where op_valid && op_ready;
  // op_valid, opcode and op_pc hold steady until then, unless pc_load or rst.

  fetch_state_t            r_state;
  fetch_state_t            w_next;
  logic [CHIP8_ADDR_W-1:0] r_pc;
  logic [CHIP8_ADDR_W-1:0] r_op_pc;
  logic [15:0]             r_opcode;
  logic [7:0]              r_hi;
  logic [CHIP8_ADDR_W-1:0] w_mem_address;
  logic [CHIP8_ADDR_W-1:0] w_pc_plus1;
  logic                    w_load;
  logic                    w_bounds_hit;

  assign w_pc_plus1 = r_pc + 12'd1;
  assign w_load     = pc_load && (r_state != S_HALT);

`ifdef CHIP8_FETCH_BOUNDS_EN
  // A fetch at 0xFFF would need its low byte from 0x000; refuse it instead.
  logic r_fault;
  assign w_bounds_hit = (r_pc == 12'hFFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (r_state == S_IDLE && w_next == S_HALT) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign w_bounds_hit = 1'b0;
  assign fault        = 1'b0;
`endif

  always_comb begin
    w_next        = r_state;
    w_mem_address = r_pc;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next = w_bounds_hit ? S_HALT : S_RD_HI;
        end
      end
      S_RD_HI:  w_next = S_RD_LO;
      S_RD_LO: begin
        w_mem_address = w_pc_plus1;
        w_next        = S_CAP_LO;
      end
      S_CAP_LO: begin
        w_mem_address = w_pc_plus1;
        w_next        = S_VALID;
      end
      S_VALID: begin
        if (op_ready) begin
          w_next = S_IDLE;
        end
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
    // A redirect aborts whatever is in flight, including a same-cycle handshake.
    if (w_load) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_op_pc  <= RESET_PC;
      r_opcode <= 16'h0000;
      r_hi     <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_pc <= pc_load_value;
      end else if (r_state == S_VALID && op_ready) begin
        r_pc <= r_pc + 12'd2;
      end
      if (!w_load && r_state == S_RD_LO) begin
        r_hi <= mem_data_out;
      end
      if (!w_load && r_state == S_CAP_LO) begin
        r_opcode <= {r_hi, mem_data_out};
        r_op_pc  <= r_pc;
      end
    end
  end

  assign mem_address = w_mem_address;
  assign op_valid    = (r_state == S_VALID);
  assign opcode      = r_opcode;
  assign op_pc       = r_op_pc;
  assign pc          = r_pc;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_chip8_fetch.sv
// Self-checking bench for chip8_fetch with a behavioural synchronous-read program
// memory; honours CHIP8_FETCH_BOUNDS_EN for the 0xFFF case.
module tb_chip8_fetch;
  import chip8_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         pc_load = 1'b0;
  logic [11:0]  pc_load_value = 12'h000;
  logic [11:0]  mem_address;
  logic [7:0]   mem_data_out = 8'h00;
  logic         op_valid;
  logic         op_ready = 1'b0;
  logic [15:0]  opcode;
  logic [11:0]  op_pc;
  logic [11:0]  pc;
  logic         fault;
  fetch_state_t dbg_state;

  logic [7:0]   mem [CHIP8_MEM_DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        use_load;
    logic [11:0] load_val;
    logic [11:0] exp_pc;
    logic [11:0] exp_op_pc;
    logic [15:0] exp_opcode;
  } vec_t;

  vec_t vecs [5];

  chip8_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_address   (mem_address),
    .mem_data_out  (mem_data_out),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .opcode        (opcode),
    .op_pc         (op_pc),
    .pc            (pc),
    .fault         (fault),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data_out <= mem[mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!op_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: op_valid timeout got 0 expected 1", name);
    end
  endtask

  // Handshake (optionally with a same-cycle redirect); returns at the negedge after.
  task automatic accept(input logic with_load, input logic [11:0] val);
    op_ready      = 1'b1;
    pc_load       = with_load;
    pc_load_value = val;
    @(negedge clk);
    op_ready = 1'b0;
    pc_load  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < CHIP8_MEM_DEPTH; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h22; mem[12'h203] = 8'h4E;
    mem[12'h300] = 8'hA2; mem[12'h301] = 8'hF0;
    mem[12'h400] = 8'h6A; mem[12'h401] = 8'h0C;
    mem[12'h456] = 8'h81; mem[12'h457] = 8'h23;
    mem[12'h458] = 8'hF0; mem[12'h459] = 8'h1E;
    mem[12'h123] = 8'hD0; mem[12'h124] = 8'h15;
    mem[12'hFFE] = 8'h00; mem[12'hFFF] = 8'hEE;
    mem[12'h000] = 8'h13; mem[12'h001] = 8'h37;

    vecs[0] = '{1'b1, 12'h456, 12'h456, 12'h456, 16'h8123};
    vecs[1] = '{1'b0, 12'h000, 12'h458, 12'h458, 16'hF01E};
    vecs[2] = '{1'b1, 12'h123, 12'h123, 12'h123, 16'hD015};
    vecs[3] = '{1'b1, 12'hFFE, 12'hFFE, 12'hFFE, 16'h00EE};
    vecs[4] = '{1'b0, 12'h000, 12'h000, 12'h000, 16'h1337};

    // Reset values
    @(negedge clk); @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h200);
    chk("rst_op_pc", 32'(op_pc), 32'h200);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_op_valid", 32'(op_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h200);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // First fetch: latency and addressing
    rst = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("f1_rdhi_addr", 32'(mem_address), 32'h200);
    @(negedge clk);
    chk("f1_rdlo_addr", 32'(mem_address), 32'h201);
    @(negedge clk);
    chk("f1_valid_T2", 32'(op_valid), 32'h0);
    @(negedge clk);
    chk("f1_valid_T3", 32'(op_valid), 32'h1);
    chk("f1_opcode", 32'(opcode), 32'h1234);
    chk("f1_op_pc", 32'(op_pc), 32'h200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("f1_hold_valid", 32'(op_valid), 32'h1);
      chk("f1_hold_opcode", 32'(opcode), 32'h1234);
      chk("f1_hold_pc", 32'(pc), 32'h200);
    end

    // Handshake -> pc+2, next opcode 4 cycles after the handshake edge
    accept(1'b0, 12'h000);
    chk("hs_pc", 32'(pc), 32'h202);
    chk("hs_valid_drop", 32'(op_valid), 32'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("f2_valid_H3", 32'(op_valid), 32'h0);
    @(negedge clk);
    chk("f2_valid_H4", 32'(op_valid), 32'h1);
    chk("f2_opcode", 32'(opcode), 32'h224E);
    chk("f2_op_pc", 32'(op_pc), 32'h202);

    // Redirect during RD_LO aborts the 0x204 fetch
    accept(1'b0, 12'h000);
    @(negedge clk); @(negedge clk);
    chk("abort_in_rdlo", 32'(dbg_state), 32'(S_RD_LO));
    pc_load = 1'b1; pc_load_value = 12'h300;
    @(negedge clk);
    pc_load = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(S_IDLE));
    chk("abort_pc", 32'(pc), 32'h300);
    wait_valid("abort_fetch");
    chk("abort_op_pc", 32'(op_pc), 32'h300);
    chk("abort_opcode", 32'(opcode), 32'hA2F0);

    // Redirect wins over a same-cycle handshake
    accept(1'b1, 12'h400);
    chk("ldhs_pc", 32'(pc), 32'h400);
    chk("ldhs_valid", 32'(op_valid), 32'h0);
    wait_valid("ldhs_fetch");
    chk("ldhs_op_pc", 32'(op_pc), 32'h400);
    chk("ldhs_opcode", 32'(opcode), 32'h6A0C);

    // Table: loads, sequential fetches, odd PC and the 0xFFE wrap
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].use_load, vecs[i].load_val);
      chk($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      wait_valid($sformatf("vec%0d_fetch", i));
      chk($sformatf("vec%0d_op_pc", i), 32'(op_pc), 32'(vecs[i].exp_op_pc));
      chk($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(vecs[i].exp_opcode));
    end

    // Fetch at 0xFFF
    accept(1'b1, 12'hFFF);
`ifdef CHIP8_FETCH_BOUNDS_EN
    @(negedge clk);
    chk("fff_state", 32'(dbg_state), 32'(S_HALT));
    chk("fff_fault", 32'(fault), 32'h1);
    chk("fff_valid", 32'(op_valid), 32'h0);
    chk("fff_addr", 32'(mem_address), 32'hFFF);
    pc_load = 1'b1; pc_load_value = 12'h200;
    @(negedge clk);
    pc_load = 1'b0;
    @(negedge clk);
    chk("halt_ignores_load", 32'(dbg_state), 32'(S_HALT));
    chk("halt_pc", 32'(pc), 32'hFFF);
`else
    wait_valid("fff_fetch");
    chk("fff_op_pc", 32'(op_pc), 32'hFFF);
    chk("fff_opcode", 32'(opcode), 32'hEE13);
    chk("fff_fault", 32'(fault), 32'h0);
`endif

    // Async reset during CAP_LO
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_valid("rst2_fetch");
    chk("rst2_opcode", 32'(opcode), 32'h1234);
    accept(1'b1, 12'h200);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("caplo_state", 32'(dbg_state), 32'(S_CAP_LO));
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("arst_opcode", 32'(opcode), 32'h0);
    chk("arst_op_pc", 32'(op_pc), 32'h200);
    chk("arst_valid", 32'(op_valid), 32'h0);
    chk("arst_addr", 32'(mem_address), 32'h200);
    chk("arst_fault", 32'(fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid("arst_refetch");
    chk("arst_refetch_op_pc", 32'(op_pc), 32'h200);
    chk("arst_refetch_opcode", 32'(opcode), 32'h1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
